// File: rtl/ntt_addr_ctrl.sv
// ntt_addr_ctrl
//   Address sequencer for an in-place radix-2 NTT that issues two butterflies
//   per cycle. For each stage s it walks k = 0..N/4-1 and reads the top/bottom
//   coefficients of pairs p0=2k and p1=2k+1. It also produces their twiddle
//   ROM addresses. The read strobe and addresses are replayed PIPE_LAT cycles
//   later as the write-back strobe and addresses.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle start pulse (ignored unless idle)
//   busy, done         transform in progress / one-cycle completion pulse
//   stage              current stage index s
//   rd_en              coefficient RAM read strobe
//   rd_a0/rd_b0        top/bottom read addresses, butterfly 0
//   rd_a1/rd_b1        top/bottom read addresses, butterfly 1
//   tw0/tw1            twiddle ROM addresses, butterflies 0/1
//   wr_en, wr_a*/wr_b* write strobe/addresses (reads delayed PIPE_LAT)

// Address generator for one butterfly lane (purely combinational).
//   p   : pair index, LOGN-1 bits
//   s   : stage index
//   top : (p/d)*2d + (p mod d), with d = N >> (s+1)
//   bot : top + d
//   tw  : 2^s + (p >> (LOGN-1-s))
module ntt_bfly_addr #(
  parameter int LOGN = 8,
  parameter int SW   = $clog2(LOGN)
) (
  input  logic [LOGN-2:0] p,
  input  logic [SW-1:0]   s,
  output logic [LOGN-1:0] top,
  output logic [LOGN-1:0] bot,
  output logic [LOGN-1:0] tw
);
  logic [SW-1:0]   sh;
  logic [LOGN-1:0] pe, d, mask;

  always_comb begin
    // d = 2^(LOGN-1-s). The mask keeps p mod d. The remaining high bits of p
    // give (p/d)*d. Shifting those bits left once yields (p/d)*2d.
    sh   = SW'(LOGN-1) - s;
    pe   = {1'b0, p};
    d    = LOGN'(1) << sh;
    mask = d - LOGN'(1);
    top  = ((pe & ~mask) << 1) | (pe & mask);
    // Bit 'd' of top is always clear, so this add never carries out.
    bot  = top + d;
    // p >> (LOGN-1-s) < 2^s, so the sum stays within LOGN bits.
    tw   = (LOGN'(1) << s) + (pe >> sh);
  end
endmodule

module ntt_addr_ctrl #(
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 8,
  localparam int SW      = $clog2(LOGN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [SW-1:0]   stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_a0,
  output logic [LOGN-1:0] rd_b0,
  output logic [LOGN-1:0] rd_a1,
  output logic [LOGN-1:0] rd_b1,
  output logic [LOGN-1:0] tw0,
  output logic [LOGN-1:0] tw1,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_a0,
  output logic [LOGN-1:0] wr_b0,
  output logic [LOGN-1:0] wr_a1,
  output logic [LOGN-1:0] wr_b1
);
  localparam int NUM_LANES = 2;
  localparam int KW        = LOGN - 2;               // k counts 0..N/4-1
  localparam int DW        = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state, nstate;
  logic [KW-1:0] k, nk;
  logic [SW-1:0] s, ns;
  logic [DW-1:0] dcnt, ndcnt;
  logic          ndone;
  logic          rd_go;

  logic [NUM_LANES-1:0][LOGN-1:0] top_n, bot_n, tw_n;
  logic [NUM_LANES-1:0][LOGN-1:0] tw_q;
  // Index 0 holds the registered read side. Index PIPE_LAT is the write-back side.
  logic [PIPE_LAT:0]                             vld_pipe;
  logic [PIPE_LAT:0][NUM_LANES-1:0][LOGN-1:0]    top_pipe, bot_pipe;

  always_comb begin
    nstate = state;
    nk     = k;
    ns     = s;
    ndcnt  = dcnt;
    ndone  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nstate = READ;
          nk     = '0;
          ns     = '0;
        end
      end
      READ: begin
        if (k == {KW{1'b1}}) begin
          nstate = DRAIN;
          ndcnt  = '0;
        end else begin
          nk = k + KW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == DW'(PIPE_LAT - 1)) begin
          nk = '0;
          if (s == SW'(LOGN - 1)) begin
            nstate = IDLE;
            ns     = '0;
            ndone  = 1'b1;
          end else begin
            nstate = READ;
            ns     = s + SW'(1);
          end
        end else begin
          ndcnt = dcnt + DW'(1);
        end
      end
      default: nstate = IDLE;
    endcase
  end

  assign rd_go = (nstate == READ);

  // The lanes look at next-state k/s. This lets the registered addresses line
  // up with rd_en, including k=0 in the first READ cycle.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ntt_bfly_addr #(.LOGN(LOGN), .SW(SW)) u_bfly (
      .p   ({nk, 1'(l)}),
      .s   (ns),
      .top (top_n[l]),
      .bot (bot_n[l]),
      .tw  (tw_n[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      s        <= '0;
      dcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vld_pipe <= '0;
      top_pipe <= '0;
      bot_pipe <= '0;
      tw_q     <= '0;
    end else begin
      state    <= nstate;
      k        <= nk;
      s        <= ns;
      dcnt     <= ndcnt;
      busy     <= (nstate != IDLE);
      done     <= ndone;
      vld_pipe <= {vld_pipe[PIPE_LAT-1:0], rd_go};
      top_pipe <= {top_pipe[PIPE_LAT-1:0], rd_go ? top_n : '0};
      bot_pipe <= {bot_pipe[PIPE_LAT-1:0], rd_go ? bot_n : '0};
      tw_q     <= rd_go ? tw_n : '0;
    end
  end

  assign stage = s;
  assign rd_en = vld_pipe[0];
  assign rd_a0 = top_pipe[0][0];
  assign rd_b0 = bot_pipe[0][0];
  assign rd_a1 = top_pipe[0][1];
  assign rd_b1 = bot_pipe[0][1];
  assign tw0   = tw_q[0];
  assign tw1   = tw_q[1];
  assign wr_en = vld_pipe[PIPE_LAT];
  assign wr_a0 = top_pipe[PIPE_LAT][0];
  assign wr_b0 = bot_pipe[PIPE_LAT][0];
  assign wr_a1 = top_pipe[PIPE_LAT][1];
  assign wr_b1 = bot_pipe[PIPE_LAT][1];
endmodule

// File: tb/tb_ntt_addr_ctrl.sv
// Scoreboard bench for ntt_addr_ctrl. Each accepted start pushes the whole
// expected read/write/done schedule of a transform into queues. A monitor
// compares the DUT against the queue heads on every falling edge.
module tb_ntt_addr_ctrl;
  localparam int LOGN = 8;
  localparam int N    = 1 << LOGN;
  localparam int PL   = 8;
  localparam int NQ   = N / 4;
  localparam int SLEN = NQ + PL;
  localparam int TLEN = LOGN * SLEN;   // busy cycles per transform

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage;
  logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1, tw0, tw1;
  logic [7:0] wr_a0, wr_b0, wr_a1, wr_b1;

  ntt_addr_ctrl #(.LOGN(LOGN), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_a0(rd_a0), .rd_b0(rd_b0),
    .rd_a1(rd_a1), .rd_b1(rd_b1), .tw0(tw0), .tw1(tw1), .wr_en(wr_en),
    .wr_a0(wr_a0), .wr_b0(wr_b0), .wr_a1(wr_a1), .wr_b1(wr_b1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int s; int k;
    int a0; int b0; int a1; int b1; int tw0; int tw1;
  } rd_t;
  typedef struct { int cyc; int a0; int b0; int a1; int b1; } wr_t;

  rd_t rdq[$];
  wr_t wrq[$];
  int  dq[$];
  int  cyc = 0;
  int  c0 = 0;
  bit  active = 1'b0;
  int  nerr = 0;
  int  nchk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference address arithmetic, written directly with divide and modulo.
  function automatic int top_of(int s, int p);
    int d;
    d = N >> (s + 1);
    return (p / d) * 2 * d + (p % d);
  endfunction

  function automatic int tw_of(int s, int p);
    return (1 << s) + (p >> (LOGN - 1 - s));
  endfunction

  task automatic push_transform(int cs);
    rd_t r;
    wr_t w;
    for (int s = 0; s < LOGN; s++) begin
      for (int k = 0; k < NQ; k++) begin
        r.cyc = cs + 1 + s * SLEN + k;
        r.s   = s;
        r.k   = k;
        r.a0  = top_of(s, 2 * k);
        r.b0  = r.a0 + (N >> (s + 1));
        r.a1  = top_of(s, 2 * k + 1);
        r.b1  = r.a1 + (N >> (s + 1));
        r.tw0 = tw_of(s, 2 * k);
        r.tw1 = tw_of(s, 2 * k + 1);
        rdq.push_back(r);
        w.cyc = r.cyc + PL;
        w.a0  = r.a0;
        w.b0  = r.b0;
        w.a1  = r.a1;
        w.b1  = r.b1;
        wrq.push_back(w);
      end
    end
    dq.push_back(cs + TLEN + 1);
  endtask

  // Drive one cycle of stimulus and update the model. Reset aborts everything.
  // A start is accepted only while idle; the done cycle counts as idle.
  task automatic step(input bit st, input bit r);
    int c;
    c = cyc;
    if (r) begin
      rdq.delete();
      wrq.delete();
      dq.delete();
      active = 1'b0;
    end else if (st && (!active || c >= c0 + TLEN + 1)) begin
      c0     = c;
      active = 1'b1;
      push_transform(c);
    end
    start = st;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    rd_t r;
    wr_t w;
    int  seen [N];
    int  bad;
    bit  bexp, dexp, rexp, wexp;
    forever begin
      @(negedge clk);
      bexp = active && (cyc >= c0 + 1) && (cyc <= c0 + TLEN);
      chk("busy", int'(busy), int'(bexp));

      dexp = (dq.size() > 0) && (dq[0] == cyc);
      if (dexp) void'(dq.pop_front());
      chk("done", int'(done), int'(dexp));

      rexp = (rdq.size() > 0) && (rdq[0].cyc == cyc);
      chk("rd_en", int'(rd_en), int'(rexp));
      if (rexp) begin
        r = rdq.pop_front();
        chk("stage", int'(stage), r.s);
        chk("rd_a0", int'(rd_a0), r.a0);
        chk("rd_b0", int'(rd_b0), r.b0);
        chk("rd_a1", int'(rd_a1), r.a1);
        chk("rd_b1", int'(rd_b1), r.b1);
        chk("tw0", int'(tw0), r.tw0);
        chk("tw1", int'(tw1), r.tw1);
        if (r.k == 0) foreach (seen[i]) seen[i] = 0;
        seen[rd_a0]++;
        seen[rd_b0]++;
        seen[rd_a1]++;
        seen[rd_b1]++;
        if (r.k == NQ - 1) begin
          bad = 0;
          foreach (seen[i]) if (seen[i] != 1) bad++;
          chk("stage_cover", bad, 0);
        end
      end else if (!bexp) begin
        chk("idle_stage", int'(stage), 0);
        chk("idle_rd_addr",
            int'(rd_a0 | rd_b0 | rd_a1 | rd_b1 | tw0 | tw1), 0);
      end

      wexp = (wrq.size() > 0) && (wrq[0].cyc == cyc);
      chk("wr_en", int'(wr_en), int'(wexp));
      if (wexp) begin
        w = wrq.pop_front();
        chk("wr_a0", int'(wr_a0), w.a0);
        chk("wr_b0", int'(wr_b0), w.b0);
        chk("wr_a1", int'(wr_a1), w.a1);
        chk("wr_b1", int'(wr_b1), w.b1);
      end
    end
  end

  initial begin : stim
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) step(1'b0, 1'b1);
    repeat ($urandom_range(2, 6)) step(1'b0, 1'b0);

    // Transform 1: extra starts at cycles 10 and 300 plus random ones.
    step(1'b1, 1'b0);
    while (cyc < c0 + TLEN + 1)
      step(bit'(cyc == c0 + 10 || cyc == c0 + 300 ||
                $urandom_range(0, 15) == 0), 1'b0);

    // Transform 2: start coincident with done, then aborted by reset at cycle 100.
    step(1'b1, 1'b0);
    while (cyc < c0 + 100)
      step(bit'($urandom_range(0, 7) == 0), 1'b0);
    repeat ($urandom_range(1, 3)) step(1'b0, 1'b1);
    repeat ($urandom_range(12, 20)) step(1'b0, 1'b0);

    // Transform 3: fresh start after reset, random spurious starts.
    step(1'b1, 1'b0);
    while (cyc < c0 + TLEN + 1)
      step(bit'($urandom_range(0, 3) == 0), 1'b0);
    repeat (6) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
